// File: rtl/gao_er2_vio_pkg.sv
// Shared constants, op codes and FSM state type for the ER2 virtual I/O responder.
package gao_vio_pkg;

  localparam int          DR_W    = 24;
  localparam logic [7:0]  CAP_TAG = 8'hA5;

  localparam logic [7:0]  OP_NOP   = 8'h00;
  localparam logic [7:0]  OP_WR    = 8'h01;
  localparam logic [7:0]  OP_SET   = 8'h02;
  localparam logic [7:0]  OP_CLR   = 8'h03;
  localparam logic [7:0]  OP_PULSE = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gao_er2_vio_if.sv
// JTAG ER2 user-register signals between the GW_JTAG primitive (master) and the responder (slave).
interface gao_er2_vio_if;

  logic tck;
  logic jtag_rst;
  logic enable;
  logic shift_dr_capture_dr;
  logic update_dr;
  logic tdi;
  logic tdo;

  modport master (
    output tck, jtag_rst, enable, shift_dr_capture_dr, update_dr, tdi,
    input  tdo
  );

  modport slave (
    input  tck, jtag_rst, enable, shift_dr_capture_dr, update_dr, tdi,
    output tdo
  );

endinterface

// File: rtl/gao_er2_vio_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line with registered rise/fall pulses.
module gao_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;
  logic                rise_q;
  logic                fall_q;

  // level_o is the delayed copy so it lines up in time with the edge pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], d_i};
      prev_q <= sync_q[SYNC_STG-1];
      rise_q <= sync_q[SYNC_STG-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STG-1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gao_er2_vio.sv
// ER2 user-register responder: 24-bit JTAG commands drive control outputs, probe status is read back.
module gao_er2_vio
  import gao_vio_pkg::*;
#(
  parameter int          OUT_W    = 16,
  parameter int          IN_W     = 16,
  parameter int          SYNC_STG = 2,
  parameter logic [15:0] OUT_RST  = 16'h0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  gao_er2_vio_if.slave     jtag,
  input  logic [IN_W-1:0]  probe_i,
  output logic [OUT_W-1:0] out_o,
  output logic [OUT_W-1:0] pulse_o,
  output logic             busy_o,
  output logic [7:0]       err_cnt_o
);

  localparam logic [OUT_W-1:0] OUT_RST_W = OUT_RST[OUT_W-1:0];

  // Line index: 0 tck, 1 jtag_rst, 2 enable, 3 sdcd, 4 update_dr, 5 tdi
  logic [5:0] jraw, jlvl, jrise, jfall;
  logic       unused_sync;

  assign jraw = {jtag.tdi, jtag.update_dr, jtag.shift_dr_capture_dr,
                 jtag.enable, jtag.jtag_rst, jtag.tck};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    gao_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .d_i     (jraw[g]),
      .level_o (jlvl[g]),
      .rise_o  (jrise[g]),
      .fall_o  (jfall[g])
    );
  end

  assign unused_sync = ^{jlvl[0], jlvl[4], jrise[5], jrise[3:1], jfall[5:1]};

  logic tck_rise, tck_fall, upd_rise, jrst_s, enable_s, sdcd_s, tdi_s;
  assign tck_rise = jrise[0];
  assign tck_fall = jfall[0];
  assign upd_rise = jrise[4];
  assign jrst_s   = jlvl[1];
  assign enable_s = jlvl[2];
  assign sdcd_s   = jlvl[3];
  assign tdi_s    = jlvl[5];

  logic [IN_W-1:0] probe_q [SYNC_STG];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STG; i++) probe_q[i] <= '0;
    end else begin
      probe_q[0] <= probe_i;
      for (int i = 1; i < SYNC_STG; i++) probe_q[i] <= probe_q[i-1];
    end
  end

  logic [15:0] probe_ext;
  always_comb begin
    probe_ext            = '0;
    probe_ext[IN_W-1:0]  = probe_q[SYNC_STG-1];
  end

  state_e            state_q;
  logic [DR_W-1:0]   sr_q;
  logic [4:0]        bit_cnt_q;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [OUT_W-1:0]  pulse_q, pulse_d;
  logic              tdo_q;
  logic [7:0]        err_cnt_q;
  logic              err_inc_d;
  logic [7:0]        op;
  logic [OUT_W-1:0]  data;

  assign op   = sr_q[DR_W-1:16];
  assign data = sr_q[OUT_W-1:0];

  // A scan of any length other than exactly DR_W bits is never trusted
  always_comb begin
    out_d     = out_q;
    pulse_d   = '0;
    err_inc_d = 1'b0;
    if (bit_cnt_q != 5'(DR_W)) begin
      err_inc_d = 1'b1;
    end else begin
      case (op)
        OP_NOP:   ;
        OP_WR:    out_d   = data;
        OP_SET:   out_d   = out_q | data;
        OP_CLR:   out_d   = out_q & ~data;
        OP_PULSE: pulse_d = data;
        default:  err_inc_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      out_q     <= OUT_RST_W;
      pulse_q   <= '0;
      tdo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pulse_q <= '0;
      if (tck_fall) tdo_q <= sr_q[0];
      if (jrst_s) begin
        state_q <= IDLE;
        out_q   <= OUT_RST_W;
      end else begin
        case (state_q)
          IDLE: begin
            if (tck_rise && enable_s && sdcd_s) begin
              sr_q      <= {CAP_TAG, probe_ext};
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
            end
          end
          SHIFT: begin
            // An update edge wins over a coincident shift edge
            if (upd_rise && enable_s) begin
              state_q <= UPDATE;
            end else if (tck_rise && enable_s && sdcd_s) begin
              sr_q <= {tdi_s, sr_q[DR_W-1:1]};
              if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
            end else if (!enable_s) begin
              state_q <= IDLE;
            end
          end
          UPDATE: begin
            state_q <= IDLE;
            out_q   <= out_d;
            pulse_q <= pulse_d;
            if (err_inc_d) err_cnt_q <= sat_inc8(err_cnt_q);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign jtag.tdo  = tdo_q;
  assign out_o     = out_q;
  assign pulse_o   = pulse_q;
  assign busy_o    = (state_q != IDLE);
  assign err_cnt_o = err_cnt_q;

endmodule
